regfile_multiport: RTL and testbench

REGFILE_MULTIPORT -- requirements
Module: regfile_multiport

---
 rtl/regfile_multiport.sv | 95 +++++++++
 tb/tb_regfile_multiport.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_multiport.sv
// Multi-port register file: NUM_READ combinational read ports, two write ports, self-clearing after reset.
// Define REGFILE_MULTIPORT_BYPASS_EN to forward same-cycle write data to matching reads.
module regfile_multiport #(
   parameter int unsigned WORD_SIZE    = 32,
   parameter int unsigned ADDRESS_SIZE = 5,
   parameter int unsigned NUM_READ     = 3
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_READ*ADDRESS_SIZE-1:0] ReadReg,
   output logic [NUM_READ*WORD_SIZE-1:0]    ReadData,
   input  logic [ADDRESS_SIZE-1:0]          WriteReg0,
   input  logic [ADDRESS_SIZE-1:0]          WriteReg1,
   input  logic [WORD_SIZE-1:0]             WriteData0,
   input  logic [WORD_SIZE-1:0]             WriteData1,
   input  logic                             RegWrite0,
   input  logic                             RegWrite1,
   output logic                             Busy
);

   localparam int unsigned DEPTH = 1 << ADDRESS_SIZE;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDRESS_SIZE-1:0] cnt_q, cnt_d;
   logic [WORD_SIZE-1:0]    mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == CLEAR) begin
         cnt_d = cnt_q + ADDRESS_SIZE'(1);
         if (cnt_q == '1) begin
            state_d = READY;
         end
      end
   end

   assign Busy = (state_q == CLEAR);

   // Port 1 is written last so it wins a same-address collision.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state_q == CLEAR) begin
            mem_q[cnt_q] <= '0;
         end else begin
            if (RegWrite0 && (WriteReg0 != '0)) begin
               mem_q[WriteReg0] <= WriteData0;
            end
            if (RegWrite1 && (WriteReg1 != '0)) begin
               mem_q[WriteReg1] <= WriteData1;
            end
         end
      end
   end

   always_comb begin
      ReadData = '0;
      for (int unsigned k = 0; k < NUM_READ; k++) begin
         logic [ADDRESS_SIZE-1:0] raddr;
         logic [WORD_SIZE-1:0]    rdata;
         raddr = ReadReg[k*ADDRESS_SIZE +: ADDRESS_SIZE];
         rdata = '0;
         if ((state_q == READY) && (raddr != '0)) begin
`ifdef REGFILE_MULTIPORT_BYPASS_EN
            if (!rst && RegWrite1 && (WriteReg1 == raddr)) begin
               rdata = WriteData1;
            end else if (!rst && RegWrite0 && (WriteReg0 == raddr)) begin
               rdata = WriteData0;
            end else begin
               rdata = mem_q[raddr];
            end
`else
            rdata = mem_q[raddr];
`endif
         end
         ReadData[k*WORD_SIZE +: WORD_SIZE] = rdata;
      end
   end

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed self-checking bench for regfile_multiport (default parameters).
module tb_regfile_multiport;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [14:0] ReadReg = '0;
   logic [95:0] ReadData;
   logic [4:0]  WriteReg0 = '0;
   logic [4:0]  WriteReg1 = '0;
   logic [31:0] WriteData0 = '0;
   logic [31:0] WriteData1 = '0;
   logic        RegWrite0 = 1'b0;
   logic        RegWrite1 = 1'b0;
   logic        Busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   regfile_multiport #(
      .WORD_SIZE    (32),
      .ADDRESS_SIZE (5),
      .NUM_READ     (3)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ReadReg    (ReadReg),
      .ReadData   (ReadData),
      .WriteReg0  (WriteReg0),
      .WriteReg1  (WriteReg1),
      .WriteData0 (WriteData0),
      .WriteData1 (WriteData1),
      .RegWrite0  (RegWrite0),
      .RegWrite1  (RegWrite1),
      .Busy       (Busy)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rd(input int unsigned port);
      return ReadData[port*32 +: 32];
   endfunction

   task automatic set_reads(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
      ReadReg[0 +: 5]  = a0;
      ReadReg[5 +: 5]  = a1;
      ReadReg[10 +: 5] = a2;
   endtask

   task automatic write_one(input int unsigned port, input logic [4:0] a, input logic [31:0] d);
      if (port == 0) begin
         WriteReg0 = a; WriteData0 = d; RegWrite0 = 1'b1;
      end else begin
         WriteReg1 = a; WriteData1 = d; RegWrite1 = 1'b1;
      end
      @(negedge clk);
      RegWrite0 = 1'b0;
      RegWrite1 = 1'b0;
   endtask

   // Counts Busy cycles after rst release; optionally presents a write to address 3 in cycle wr_at.
   task automatic count_busy(input int wr_at, output int n);
      n = 0;
      while (n < 200) begin
         #1;
         if (!Busy) break;
         n++;
         set_reads(5'd31, 5'(n), 5'd17);
         #1;
         check_eq("busy_read_p0", rd(0), 32'h0);
         check_eq("busy_read_p1", rd(1), 32'h0);
         check_eq("busy_read_p2", rd(2), 32'h0);
         RegWrite0 = 1'b0;
         if (n == wr_at) begin
            WriteReg0 = 5'd3; WriteData0 = 32'h3333_3333; RegWrite0 = 1'b1;
         end
         @(negedge clk);
      end
      RegWrite0 = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      for (int i = 0; i < 32; i++) begin
         set_reads(5'(i), 5'(i), 5'(i));
         #1;
         check_eq(tag, rd(i % 3), 32'h0);
      end
   endtask

   initial begin
      int n;
      logic [31:0] exp_bp;

      // Reset release: rst high for two cycles
      rst = 1'b1;
      @(negedge clk);
      check_eq("busy_in_reset", 32'(Busy), 32'h1);
      @(negedge clk);
      rst = 1'b0;
      count_busy(-1, n);
      check_eq("busy_len_initial", 32'(n), 32'd32);
      check_eq("busy_low_ready", 32'(Busy), 32'h0);
      check_all_zero("ready_zero");

      // Port 1 wins a same-address collision
      WriteReg0 = 5'd5; WriteData0 = 32'h1111_1111; RegWrite0 = 1'b1;
      WriteReg1 = 5'd5; WriteData1 = 32'h2222_2222; RegWrite1 = 1'b1;
      @(negedge clk);
      RegWrite0 = 1'b0; RegWrite1 = 1'b0;
      set_reads(5'd5, 5'd5, 5'd5);
      #1;
      check_eq("prio_p0", rd(0), 32'h2222_2222);
      check_eq("prio_p2", rd(2), 32'h2222_2222);

      // Independent single-port writes
      write_one(0, 5'd7, 32'h0707_0707);
      write_one(1, 5'd8, 32'h0808_0808);
      set_reads(5'd7, 5'd8, 5'd5);
      #1;
      check_eq("wr_p0", rd(0), 32'h0707_0707);
      check_eq("wr_p1", rd(1), 32'h0808_0808);
      check_eq("wr_keep5", rd(2), 32'h2222_2222);

      // Zero register discards writes
      WriteReg0 = 5'd0; WriteData0 = 32'hDEAD_BEEF; RegWrite0 = 1'b1;
      WriteReg1 = 5'd0; WriteData1 = 32'hDEAD_BEEF; RegWrite1 = 1'b1;
      set_reads(5'd0, 5'd0, 5'd0);
      #1;
      check_eq("zero_same_cycle", rd(1), 32'h0);
      @(negedge clk);
      RegWrite0 = 1'b0; RegWrite1 = 1'b0;
      #1;
      check_eq("zero_p0", rd(0), 32'h0);
      check_eq("zero_p1", rd(1), 32'h0);
      check_eq("zero_p2", rd(2), 32'h0);

      // Same-cycle forwarding to port 2
`ifdef REGFILE_MULTIPORT_BYPASS_EN
      exp_bp = 32'hCAFE_F00D;
`else
      exp_bp = 32'h0;
`endif
      WriteReg0 = 5'd9; WriteData0 = 32'hCAFE_F00D; RegWrite0 = 1'b1;
      set_reads(5'd7, 5'd0, 5'd9);
      #1;
      check_eq("bypass_same", rd(2), exp_bp);
      check_eq("bypass_other", rd(0), 32'h0707_0707);
      @(negedge clk);
      RegWrite0 = 1'b0;
      #1;
      check_eq("bypass_next", rd(2), 32'hCAFE_F00D);

`ifdef REGFILE_MULTIPORT_BYPASS_EN
      exp_bp = 32'hBBBB_BBBB;
`else
      exp_bp = 32'hCAFE_F00D;
`endif
      WriteReg0 = 5'd9; WriteData0 = 32'hAAAA_AAAA; RegWrite0 = 1'b1;
      WriteReg1 = 5'd9; WriteData1 = 32'hBBBB_BBBB; RegWrite1 = 1'b1;
      #1;
      check_eq("bypass_both", rd(2), exp_bp);
      @(negedge clk);
      RegWrite0 = 1'b0; RegWrite1 = 1'b0;
      #1;
      check_eq("bypass_both_next", rd(2), 32'hBBBB_BBBB);

      // Reset mid-clear restarts the sequence; write to 3 during clear is lost
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check_eq("midclear_busy", 32'(Busy), 32'h1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      count_busy(10, n);
      check_eq("busy_len_midclear", 32'(n), 32'd32);
      set_reads(5'd3, 5'd9, 5'd5);
      #1;
      check_eq("midclear_addr3", rd(0), 32'h0);
      check_eq("midclear_addr9", rd(1), 32'h0);

      // Fill 1..31 with own index, then reset from READY
      for (int i = 1; i < 32; i++) begin
         write_one(i % 2, 5'(i), 32'(i));
      end
      set_reads(5'd31, 5'd17, 5'd1);
      #1;
      check_eq("fill_31", rd(0), 32'd31);
      check_eq("fill_17", rd(1), 32'd17);
      check_eq("fill_1", rd(2), 32'd1);
      rst = 1'b1;
      WriteReg0 = 5'd2; WriteData0 = 32'hFFFF_FFFF; RegWrite0 = 1'b1;
      @(negedge clk);
      RegWrite0 = 1'b0;
      rst = 1'b0;
      count_busy(-1, n);
      check_eq("busy_len_ready_rst", 32'(n), 32'd32);
      check_all_zero("after_ready_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
